// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with shift counter and done pulse.
// Optional rotate modes are enabled by defining SHIFT_REG_UNIV_ROTATE_EN.
module shift_reg_univ #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             din,
    input  logic                         sin_l,
    input  logic                         sin_r,
    output logic [WIDTH-1:0]             dout,
    output logic                         sout_msb,
    output logic                         sout_lsb,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_SHL   = 3'b001,
        OP_SHR   = 3'b010,
        OP_LOAD  = 3'b011,
        OP_ROL   = 3'b100,
        OP_ROR   = 3'b101,
        OP_CLEAR = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    op_e               op;
    logic [WIDTH-1:0]  dout_nxt;
    logic [CW-1:0]     cnt_nxt;
    logic              done_nxt;
    logic              shift;
    logic              restart;

    assign op = op_e'(mode);

    // Data path selection; unlisted and reserved codes fall through to hold.
    always_comb begin
        dout_nxt = dout;
        shift    = 1'b0;
        restart  = 1'b0;
        case (op)
            OP_SHL: begin
                dout_nxt = {dout[WIDTH-2:0], sin_l};
                shift    = 1'b1;
            end
            OP_SHR: begin
                dout_nxt = {sin_r, dout[WIDTH-1:1]};
                shift    = 1'b1;
            end
`ifdef SHIFT_REG_UNIV_ROTATE_EN
            OP_ROL: begin
                dout_nxt = {dout[WIDTH-2:0], dout[WIDTH-1]};
                shift    = 1'b1;
            end
            OP_ROR: begin
                dout_nxt = {dout[0], dout[WIDTH-1:1]};
                shift    = 1'b1;
            end
`endif
            OP_LOAD: begin
                dout_nxt = din;
                restart  = 1'b1;
            end
            OP_CLEAR: begin
                dout_nxt = RESET_VAL;
                restart  = 1'b1;
            end
            default: begin
                dout_nxt = dout;
            end
        endcase
    end

    // Counter saturates at WIDTH; done fires only on the WIDTH-1 -> WIDTH step.
    always_comb begin
        cnt_nxt  = shift_cnt;
        done_nxt = 1'b0;
        if (en) begin
            if (restart) begin
                cnt_nxt = '0;
            end else if (shift && (shift_cnt < CW'(WIDTH))) begin
                cnt_nxt  = shift_cnt + CW'(1);
                done_nxt = (shift_cnt == CW'(WIDTH - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout      <= RESET_VAL;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else begin
            if (en) begin
                dout      <= dout_nxt;
                shift_cnt <= cnt_nxt;
            end
            done <= done_nxt;
        end
    end

    assign sout_msb = dout[WIDTH-1];
    assign sout_lsb = dout[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8): directed vector table
// followed by randomized stimulus against an arithmetic reference model.
module tb_shift_reg_univ;

    logic        clk = 1'b0;
    logic        reset, en, sin_l, sin_r;
    logic [2:0]  mode;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        sout_msb, sout_lsb, done;
    logic [3:0]  shift_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din),
        .sin_l(sin_l), .sin_r(sin_r), .dout(dout), .sout_msb(sout_msb),
        .sout_lsb(sout_lsb), .shift_cnt(shift_cnt), .done(done)
    );

    typedef struct {
        logic       reset;
        logic       en;
        logic [2:0] mode;
        logic [7:0] din;
        logic       sl;
        logic       sr;
        logic [7:0] ed;
        logic [3:0] ec;
        logic       edn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] d, input logic sl, input logic sr,
                       input logic [7:0] ed, input logic [3:0] ec, input logic edn);
        vec_t v;
        v = '{reset: r, en: e, mode: m, din: d, sl: sl, sr: sr, ed: ed, ec: ec, edn: edn};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag, input logic [7:0] ed, input logic [3:0] ec,
                             input logic edn);
        check({tag, " dout"},      64'(dout),      64'(ed));
        check({tag, " shift_cnt"}, 64'(shift_cnt), 64'(ec));
        check({tag, " done"},      64'(done),      64'(edn));
        check({tag, " sout_msb"},  64'(sout_msb),  64'(ed[7]));
        check({tag, " sout_lsb"},  64'(sout_lsb),  64'(ed[0]));
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] m,
                         input logic [7:0] d, input logic sl, input logic sr);
        reset = r; en = e; mode = m; din = d; sin_l = sl; sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: plain integers, updated from the mode rules.
    int m_d, m_c, m_done;

    task automatic model_step(input logic r, input logic e, input logic [2:0] m,
                              input logic [7:0] d, input logic sl, input logic sr);
        int adv;
        adv    = 0;
        m_done = 0;
        if (r) begin
            m_d = 0; m_c = 0;
        end else if (e) begin
            case (m)
                3'd1: begin m_d = (m_d * 2 + int'(sl)) % 256; adv = 1; end
                3'd2: begin m_d = m_d / 2 + int'(sr) * 128;   adv = 1; end
                3'd3: begin m_d = int'(d); m_c = 0; end
`ifdef SHIFT_REG_UNIV_ROTATE_EN
                3'd4: begin m_d = (m_d * 2 + m_d / 128) % 256;   adv = 1; end
                3'd5: begin m_d = m_d / 2 + (m_d % 2) * 128;     adv = 1; end
`endif
                3'd6: begin m_d = 0; m_c = 0; end
                default: ;
            endcase
            if (adv != 0 && m_c < 8) begin
                m_done = (m_c == 7) ? 1 : 0;
                m_c    = m_c + 1;
            end
        end
    endtask

    initial begin
        logic [7:0] shr_exp [8];
        logic [7:0] shl_exp [8];
        logic [7:0] shl_in;
        logic [7:0] s3c_exp [7];
        logic [7:0] r, e;

        shr_exp = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
        shl_exp = '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h19, 8'h32, 8'h65, 8'hCB};
        shl_in  = 8'b1101_0011;  // bit i is the sin_l value for shift i
        s3c_exp = '{8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00};

        // Reset wins over LOAD.
        add(1, 1, 3'd3, 8'hFF, 0, 0, 8'h00, 4'd0, 0);
        // LOAD A5, 9x SHR.
        add(0, 1, 3'd3, 8'hA5, 0, 0, 8'hA5, 4'd0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 3'd2, 8'h00, 0, 0, shr_exp[i], 4'(i + 1), (i == 7) ? 1'b1 : 1'b0);
        add(0, 1, 3'd2, 8'h00, 0, 0, 8'h00, 4'd8, 0);
        // LOAD 00, 8x SHL with serial pattern 1,1,0,0,1,0,1,1.
        add(0, 1, 3'd3, 8'h00, 0, 0, 8'h00, 4'd0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 3'd1, 8'h00, shl_in[i], 0, shl_exp[i], 4'(i + 1), (i == 7) ? 1'b1 : 1'b0);
        add(0, 1, 3'd0, 8'h00, 0, 0, 8'hCB, 4'd8, 0);
        // LOAD 81 then ROL (behaviour depends on build).
        add(0, 1, 3'd3, 8'h81, 0, 0, 8'h81, 4'd0, 0);
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        add(0, 1, 3'd4, 8'h00, 0, 0, 8'h03, 4'd1, 0);
        add(0, 1, 3'd5, 8'h00, 0, 0, 8'h81, 4'd2, 0);
`else
        add(0, 1, 3'd4, 8'h00, 0, 0, 8'h81, 4'd0, 0);
        add(0, 1, 3'd5, 8'h00, 0, 0, 8'h81, 4'd0, 0);
`endif
        // LOAD 3C, 7x SHL, en=0 x3, final SHL, then HOLD.
        add(0, 1, 3'd3, 8'h3C, 0, 0, 8'h3C, 4'd0, 0);
        for (int i = 0; i < 7; i++)
            add(0, 1, 3'd1, 8'h00, 0, 0, s3c_exp[i], 4'(i + 1), 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 3'd1, 8'hFF, 1, 1, 8'h00, 4'd7, 0);
        add(0, 1, 3'd1, 8'h00, 0, 0, 8'h00, 4'd8, 1);
        add(0, 0, 3'd1, 8'h00, 0, 0, 8'h00, 4'd8, 0);
        // LOAD 3C, 7x SHL, CLEAR in place of the 8th shift.
        add(0, 1, 3'd3, 8'h3C, 0, 0, 8'h3C, 4'd0, 0);
        for (int i = 0; i < 7; i++)
            add(0, 1, 3'd1, 8'h00, 0, 0, s3c_exp[i], 4'(i + 1), 0);
        add(0, 1, 3'd6, 8'h00, 0, 0, 8'h00, 4'd0, 0);
        add(0, 1, 3'd0, 8'h00, 0, 0, 8'h00, 4'd0, 0);
        // LOAD in place of the 8th shift.
        add(0, 1, 3'd3, 8'hFF, 0, 0, 8'hFF, 4'd0, 0);
        for (int i = 0; i < 7; i++)
            add(0, 1, 3'd1, 8'h00, 1, 0, 8'hFF, 4'(i + 1), 0);
        add(0, 1, 3'd3, 8'h12, 0, 0, 8'h12, 4'd0, 0);
        // Reset mid-stream aborts the count.
        for (int i = 0; i < 7; i++)
            add(0, 1, 3'd2, 8'h00, 0, 1, 8'h12, 4'(i + 1), 0);
        add(1, 1, 3'd2, 8'h00, 0, 1, 8'h00, 4'd0, 0);
        add(0, 1, 3'd0, 8'h00, 0, 0, 8'h00, 4'd0, 0);
        // Reserved/HOLD after LOAD 5A.
        add(0, 1, 3'd3, 8'h5A, 0, 0, 8'h5A, 4'd0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 1, (i % 2 == 0) ? 3'd7 : 3'd0, 8'hFF, 1, 1, 8'h5A, 4'd0, 0);

        // Fix up the mid-stream reset rows: SHR with sin_r=1 from 0x12.
        e = 8'h12;
        foreach (vecs[k]) begin
            if (vecs[k].mode == 3'd2 && vecs[k].sr && !vecs[k].reset) begin
                e = {1'b1, e[7:1]};
                vecs[k].ed = e;
            end
        end

        foreach (vecs[k]) begin
            drive(vecs[k].reset, vecs[k].en, vecs[k].mode, vecs[k].din, vecs[k].sl, vecs[k].sr);
            check_all($sformatf("vec%0d", k), vecs[k].ed, vecs[k].ec, vecs[k].edn);
        end

        // Randomized phase against the reference model.
        drive(1, 0, 3'd0, 8'h00, 0, 0);
        m_d = 0; m_c = 0; m_done = 0;
        for (int i = 0; i < 600; i++) begin
            logic       rr, ee, sl, sr;
            logic [2:0] mm;
            logic [7:0] dd;
            rr = ($urandom_range(0, 40) == 0);
            ee = ($urandom_range(0, 3) != 0);
            // Bias towards shifts so the counter saturates regularly.
            mm = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
            dd = 8'($urandom);
            sl = 1'($urandom);
            sr = 1'($urandom);
            model_step(rr, ee, mm, dd, sl, sr);
            drive(rr, ee, mm, dd, sl, sr);
            r = 8'(m_d);
            check_all($sformatf("rnd%0d", i), r, 4'(m_c), 1'(m_done));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
